// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, angle table and mode encodings
package cordic_pkg;

   localparam int TABLE_FRAC = 30;

   // atan(2^-i) scaled by 2^30, truncated
   localparam logic [31:0] ATAN_Q30 [0:29] = '{
      32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6, 32'h03FEAB76,
      32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55, 32'h003FFFEA, 32'h001FFFFD,
      32'h000FFFFF, 32'h0007FFFF, 32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF,
      32'h00007FFF, 32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
      32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F, 32'h0000003F,
      32'h0000001F, 32'h0000000F, 32'h00000007, 32'h00000003, 32'h00000001
   };

   localparam logic [31:0] CORDIC_K_Q30 = 32'h26DD3B6A;

   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   function automatic logic [31:0] q30_to_frac(input logic [31:0] v, input int frac_w);
      return v >> (TABLE_FRAC - frac_w);
   endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// rtl/cordic_pipe_stage.sv - one registered CORDIC micro-rotation carrying valid and mode
module cordic_pipe_stage
   import cordic_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 22,
   parameter int                    SHIFT        = 0,
   parameter logic [DATA_WIDTH-1:0] ATAN         = '0,
   parameter bit                    HOLD_INVALID = 1'b0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_en,
   input  logic                         i_valid,
   input  logic                         i_mode,
   input  logic signed [DATA_WIDTH-1:0] i_x,
   input  logic signed [DATA_WIDTH-1:0] i_y,
   input  logic signed [DATA_WIDTH-1:0] i_z,
   output logic                         o_valid,
   output logic                         o_mode,
   output logic signed [DATA_WIDTH-1:0] o_x,
   output logic signed [DATA_WIDTH-1:0] o_y,
   output logic signed [DATA_WIDTH-1:0] o_z
);

   logic                         r_valid;
   logic                         r_mode;
   logic signed [DATA_WIDTH-1:0] r_x, r_y, r_z;

   logic                         w_d_pos;
   logic                         w_load;
   logic signed [DATA_WIDTH-1:0] w_x_sh, w_y_sh;
   logic signed [DATA_WIDTH-1:0] w_x_nxt, w_y_nxt, w_z_nxt;

   always_comb begin
      w_d_pos = (i_mode == MODE_VEC) ? i_y[DATA_WIDTH-1] : ~i_z[DATA_WIDTH-1];
      w_x_sh  = i_x >>> SHIFT;
      w_y_sh  = i_y >>> SHIFT;
      w_x_nxt = w_d_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
      w_y_nxt = w_d_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
      w_z_nxt = w_d_pos ? (i_z - $signed(ATAN)) : (i_z + $signed(ATAN));
      // the output stage keeps its last result while no valid sample arrives
      w_load  = i_en && (!HOLD_INVALID || i_valid);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_mode  <= MODE_ROT;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
      end else begin
         if (i_en) r_valid <= i_valid;
         if (w_load) begin
            r_mode <= i_mode;
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_z    <= w_z_nxt;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_mode  = r_mode;
   assign o_x     = r_x;
   assign o_y     = r_y;
   assign o_z     = r_z;

endmodule

// File: rtl/cordic_pipeline.sv
// rtl/cordic_pipeline.sv - fully pipelined rotation/vectoring CORDIC engine with stall enable
module cordic_pipeline
   import cordic_pkg::*;
#(
   parameter int INTEGER_WIDTH    = 2,
   parameter int FRACTIONAL_WIDTH = 20,
   parameter int DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH,
   parameter int STAGES           = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic                         in_valid,
   input  logic                         in_mode,
   input  logic signed [DATA_WIDTH-1:0] in_x,
   input  logic signed [DATA_WIDTH-1:0] in_y,
   input  logic signed [DATA_WIDTH-1:0] in_z,
   output logic                         out_valid,
   output logic                         out_mode,
   output logic signed [DATA_WIDTH-1:0] out_x,
   output logic signed [DATA_WIDTH-1:0] out_y,
   output logic signed [DATA_WIDTH-1:0] out_z
);

   logic                         w_valid [0:STAGES];
   logic                         w_mode  [0:STAGES];
   logic signed [DATA_WIDTH-1:0] w_x     [0:STAGES];
   logic signed [DATA_WIDTH-1:0] w_y     [0:STAGES];
   logic signed [DATA_WIDTH-1:0] w_z     [0:STAGES];

   // vectoring accumulates the angle from zero, so the caller's z is discarded
   assign w_valid[0] = in_valid;
   assign w_mode[0]  = in_mode;
   assign w_x[0]     = in_x;
   assign w_y[0]     = in_y;
   assign w_z[0]     = (in_mode == MODE_VEC) ? '0 : in_z;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      cordic_pipe_stage #(
         .DATA_WIDTH   (DATA_WIDTH),
         .SHIFT        (i),
         .ATAN         (DATA_WIDTH'(q30_to_frac(ATAN_Q30[i], FRACTIONAL_WIDTH))),
         .HOLD_INVALID (i == STAGES - 1)
      ) u_stage (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_en    (clk_en),
         .i_valid (w_valid[i]),
         .i_mode  (w_mode[i]),
         .i_x     (w_x[i]),
         .i_y     (w_y[i]),
         .i_z     (w_z[i]),
         .o_valid (w_valid[i+1]),
         .o_mode  (w_mode[i+1]),
         .o_x     (w_x[i+1]),
         .o_y     (w_y[i+1]),
         .o_z     (w_z[i+1])
      );
   end

   assign out_valid = w_valid[STAGES];
   assign out_mode  = w_mode[STAGES];
   assign out_x     = w_x[STAGES];
   assign out_y     = w_y[STAGES];
   assign out_z     = w_z[STAGES];

endmodule

// File: doc/cordic_pipeline.md
# cordic_pipeline

Parametrised, fully pipelined CORDIC engine: next generation of the unrolled 16-stage cosine pipeline. Supports configurable word width and stage count, per-sample rotation/vectoring mode, and a valid qualifier travelling with each sample. `clk_en` acts as a pipeline stall, not a flush. Sits between the angle/vector source and the trig consumers, accepting one sample per enabled cycle.

## Interface
- `INTEGER_WIDTH`, 2, signed integer bits of every data word, including the sign bit.
- `FRACTIONAL_WIDTH`, 20, fractional bits; legal range 8..30.
- `DATA_WIDTH`, `INTEGER_WIDTH+FRACTIONAL_WIDTH`, derived; not overridden.
- `STAGES`, 16, number of micro-rotations; must satisfy 1 ≤ STAGES ≤ FRACTIONAL_WIDTH.

Ports:
- `clk  in  1`  single clock, rising edge.
- `rst  in  1`  reset: synchronous, active-high.
- `clk_en  in  1`  high advances the whole pipeline one step; low freezes every register.
- `in_valid  in  1`  sample present on the `in_*` ports.
- `in_mode  in  1`  0 = rotation, 1 = vectoring.
- `in_x, in_y  in  DATA_WIDTH`  signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH) start vector.
- `in_z  in  DATA_WIDTH`  signed start angle in radians; ignored in vectoring mode, where z starts at 0.
- `out_valid  out  1`  result present.
- `out_mode  out  1`  mode of the emerging sample.
- `out_x, out_y, out_z  out  DATA_WIDTH`  signed final x, y, z.

## Operation
- Stage i (i = 0..STAGES-1) applies:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·ATAN[i]
- Direction d:
  - Rotation: d = +1 if z ≥ 0, else −1.
  - Vectoring: d = +1 if y < 0, else −1.
- Each stage uses the mode bit carried with its own sample, so modes may interleave every cycle.
- `>>>` is an arithmetic shift that truncates toward −∞.
- Add/subtract are DATA_WIDTH two's-complement and wrap; there is no saturation and no guard bits.
- Rotation results:
  - (out_x, out_y) = K⁻¹·rotate((in_x, in_y), in_z).
  - Caller drives in_x = CORDIC_K, in_y = 0 to obtain out_x = cos, out_y = sin.
- Vectoring results:
  - out_x = K⁻¹·|(x, y)|, with K⁻¹ ≈ 1.64676.
  - out_z = atan(in_y/in_x), valid for in_x > 0.
- Input range the caller must guarantee; outside it the result is undefined but the pipeline must not hang:
  - Rotation: |in_z| ≤ π/2 and |(in_x, in_y)| ≤ 1.
  - Vectoring: |(in_x, in_y)| ≤ 1.2.
- Data registers load unconditionally whenever `clk_en` is high; `valid` marks meaningful slots. Data in invalid slots is don't-care, but out_x/y/z must hold their previous value while out_valid = 0.
- No backpressure input; the consumer must accept every `out_valid` cycle in which `clk_en` is high.

## Timing
- Latency: STAGES enabled cycles from an edge sampling `in_valid` = 1 to the edge asserting `out_valid`. Stage 0 registers the inputs directly; stage STAGES-1 drives the outputs. Default latency is 16.
- Throughput: one sample per enabled cycle.
- `clk_en` = 0:
  - All valid, mode and data registers hold.
  - `in_*` is not sampled.
  - Outputs are held stable.
  - Latency stretches by exactly the number of stalled cycles.
- Reset:
  - `rst` = 1 at an edge clears every valid bit and zeroes `out_x`, `out_y`, `out_z` and `out_mode`.
  - `rst` takes priority over `clk_en`.
  - A reset mid-stream discards all in-flight samples: out_valid = 0 from the next cycle, and no pre-reset sample ever emerges.
- A sample presented in the same cycle that `rst` is high is dropped.

## Structure
- Shared package `cordic_pkg`:
  - `ATAN_Q30[0:29]`: atan(2^−i) at 30 fractional bits, truncated. Shifted right by (30 − FRACTIONAL_WIDTH) at elaboration. At 20 bits, entry 0 = 823549 and entry 1 = 486169.
  - `CORDIC_K_Q30`, giving 636750 at 20 fractional bits.
  - Mode encodings `MODE_ROT` = 0 and `MODE_VEC` = 1.
- Sub-module `cordic_pipe_stage`:
  - One registered micro-rotation with parameters `SHIFT`, `ATAN` and `DATA_WIDTH`.
  - Carries valid and mode.
  - Instantiated STAGES times by a generate loop.

## Test plan
All numeric checks use a tolerance of ±32 LSB at defaults.
- Rotation, x = 636750, y = 0, z = 0 → after 16 cycles out_valid = 1, out_x ≈ 1048576, out_y ≈ 0, out_mode = 0.
- Rotation, x = 636750, y = 0, z = 823549 (π/4) → out_x ≈ out_y ≈ 741455. Repeat with z = −823549 → out_y ≈ −741455.
- Vectoring, x = y = 524288 → out_z ≈ 823549, out_y ≈ 0, out_x ≈ 1221004, out_mode = 1.
- 32 back-to-back samples alternating mode → 32 consecutive out_valid cycles, in order, each correct for its own mode.
- `clk_en` low for 5 cycles while 8 samples are in flight → outputs frozen during the stall; all 8 emerge once each, 5 cycles late.
- `rst` pulsed for 1 cycle with 10 samples in flight → out_valid = 0 and outputs = 0 from the next cycle. A fresh sample applied after reset emerges 16 cycles later, with no stale output in between.
